dac_frame_serializer: RTL and testbench

DAC_FRAME_SERIALIZER -- requirements
Module: dac_frame_serializer

---
 rtl/dac_frame_serializer_pkg.sv | 39 +++
 rtl/dac_frame_serializer_sclk.sv | 49 ++++
 rtl/dac_frame_serializer.sv | 162 ++++++++++++++++
 tb/tb_dac_frame_serializer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_frame_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dac_frame_serializer_pkg                                      |
// | Brief    : Shared ADC/DAC serial-link constants, FSM encoding and the    |
// |            16-bit DAC frame builder.                                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package dac_frame_serializer_pkg;

   // Serial frame layout: 2 control bits, 2 power-down bits, 12-bit code
   localparam int         FRAME_LEN       = 16;
   localparam int         DAC_CODE_W      = 12;
   localparam logic [1:0] FRAME_CTRL_BITS = 2'b00;
   localparam logic [1:0] FRAME_PD_BITS   = 2'b00;

   // Legal ranges of the SCLK divider and the inter-frame Sync gap
   localparam int SCLK_DIV_MIN = 1;
   localparam int SCLK_DIV_MAX = 255;
   localparam int SYNC_GAP_MIN = 1;
   localparam int SYNC_GAP_MAX = 15;

   // Tick counter width covers SCLK_DIV_MAX
   localparam int TICK_CNT_W = 8;

   // Serializer FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   typedef logic [FRAME_LEN-1:0] dac_frame_t;

   // Assemble the on-wire frame from an offset-binary DAC code
   function automatic dac_frame_t build_dac_frame(input logic [DAC_CODE_W-1:0] code);
      return {FRAME_CTRL_BITS, FRAME_PD_BITS, code};
   endfunction

endpackage
`default_nettype wire

// File: rtl/dac_frame_serializer_sclk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sclk_tick_gen                                                 |
// | Brief    : SCLK half-period tick counter with toggle flop. Counts        |
// |            0..DIV-1 while enabled; each wrap toggles sclk unless hold    |
// |            forces it high. restart re-arms to count 0 with sclk high.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sclk_tick_gen
   import dac_frame_serializer_pkg::*;
#(
   parameter int DIV = 2
)(
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   input  logic hold,
   output logic sclk,
   output logic wrap
);

   // Out-of-range dividers are pinned to the nearest legal value
   localparam int DIV_EFF = (DIV < SCLK_DIV_MIN) ? SCLK_DIV_MIN :
                            (DIV > SCLK_DIV_MAX) ? SCLK_DIV_MAX : DIV;
   localparam logic [TICK_CNT_W-1:0] CNT_LAST = TICK_CNT_W'(DIV_EFF - 1);

   logic [TICK_CNT_W-1:0] cnt;

   // wrap marks the last system clock of a half-period; sclk changes on the next edge
   assign wrap = en && !restart && (cnt == CNT_LAST);

   // Half-period counter and SCLK toggle flop
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt  <= '0;
         sclk <= 1'b1;
      end else if (en) begin
         if (cnt == CNT_LAST) begin
            cnt  <= '0;
            sclk <= hold ? 1'b1 : ~sclk;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dac_frame_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dac_frame_serializer                                          |
// | Brief    : Converts signed samples to offset binary and shifts them out  |
// |            as 16-bit SPI-style frames (Sync low, MSB first, data stable  |
// |            across SCLK falling edges) with a one-entry pending buffer.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module dac_frame_serializer
   import dac_frame_serializer_pkg::*;
#(
   parameter int N_DAC = 12,
   parameter int DIV   = 2,
   parameter int GAP   = 2
)(
   input  logic             clock_In,
   input  logic             Reset,
   input  logic             start,
   input  logic             sample_valid,
   input  logic [N_DAC-1:0] data_In,
   output logic             Sclk_DAC,
   output logic             Sync,
   output logic             Data_DAC,
   output logic             busy,
   output logic             frame_done,
   output logic             overrun
);

   localparam int GAP_EFF = (GAP < SYNC_GAP_MIN) ? SYNC_GAP_MIN :
                            (GAP > SYNC_GAP_MAX) ? SYNC_GAP_MAX : GAP;
   // The gap is measured in SCLK half-periods (two per full period)
   localparam logic [4:0] GAP_LAST = 5'(2 * GAP_EFF - 1);
   localparam logic [3:0] BIT_LAST = 4'(FRAME_LEN - 1);

   logic [1:0]            state;
   logic                  pending;
   logic [N_DAC-1:0]      pending_data;
   logic [N_DAC-1:0]      offset_code;
   logic [DAC_CODE_W-1:0] code;
   dac_frame_t            frame;
   dac_frame_t            shift_reg;
   logic [3:0]            bit_cnt;
   logic [4:0]            gap_cnt;
   logic                  tick_en;
   logic                  tick_restart;
   logic                  tick_hold;
   logic                  tick_wrap;
   logic                  sclk_int;
   logic                  sclk_rise_due;

   // Offset binary: flipping the sign bit maps -2^(N-1)..2^(N-1)-1 onto 0..2^N-1
   assign offset_code = {~pending_data[N_DAC-1], pending_data[N_DAC-2:0]};

   generate
      if (N_DAC < DAC_CODE_W) begin : g_code_pad
         assign code = {offset_code, {(DAC_CODE_W - N_DAC){1'b0}}};
      end else if (N_DAC == DAC_CODE_W) begin : g_code_exact
         assign code = offset_code;
      end else begin : g_code_trunc
         assign code = offset_code[N_DAC-1 -: DAC_CODE_W];
      end
   endgenerate

   assign frame = build_dac_frame(code);

   // The tick generator is re-armed in LOAD so every frame starts on a fresh half-period
   assign tick_en       = (state == ST_SHIFT) || (state == ST_GAP);
   assign tick_restart  = (state == ST_LOAD);
   assign tick_hold     = (state == ST_GAP);
   assign sclk_rise_due = tick_wrap && !sclk_int;

   sclk_tick_gen #(
      .DIV     (DIV)
   ) u_sclk_tick_gen (
      .clk     (clock_In),
      .rst     (Reset),
      .en      (tick_en),
      .restart (tick_restart),
      .hold    (tick_hold),
      .sclk    (sclk_int),
      .wrap    (tick_wrap)
   );

   assign Sclk_DAC = sclk_int;
   assign busy     = (state != ST_IDLE);
   // In LOAD the pending sample is being consumed, so a new strobe there loses nothing
   assign overrun  = !Reset && sample_valid && pending && (state != ST_LOAD);

   // One-entry pending slot: latest sample wins, LOAD empties it unless refilled that cycle
   always_ff @(posedge clock_In) begin
      if (Reset) begin
         pending      <= 1'b0;
         pending_data <= '0;
      end else if (sample_valid) begin
         pending      <= 1'b1;
         pending_data <= data_In;
      end else if (state == ST_LOAD) begin
         pending      <= 1'b0;
      end
   end

   // Frame sequencer: load, shift on SCLK rising transitions, then hold Sync high for the gap
   always_ff @(posedge clock_In) begin
      if (Reset) begin
         state      <= ST_IDLE;
         Sync       <= 1'b1;
         Data_DAC   <= 1'b0;
         frame_done <= 1'b0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         gap_cnt    <= '0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start && pending) begin
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               // MSB goes out immediately so it is settled before the first falling edge
               Data_DAC  <= frame[FRAME_LEN-1];
               shift_reg <= {frame[FRAME_LEN-2:0], 1'b0};
               Sync      <= 1'b0;
               bit_cnt   <= '0;
               state     <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (sclk_rise_due) begin
                  if (bit_cnt == BIT_LAST) begin
                     // SCLK returns high after the last sampled bit: close the frame
                     Sync       <= 1'b1;
                     Data_DAC   <= 1'b0;
                     frame_done <= 1'b1;
                     gap_cnt    <= '0;
                     state      <= ST_GAP;
                  end else begin
                     Data_DAC  <= shift_reg[FRAME_LEN-1];
                     shift_reg <= {shift_reg[FRAME_LEN-2:0], 1'b0};
                     bit_cnt   <= bit_cnt + 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (tick_wrap) begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     state   <= (start && pending) ? ST_LOAD : ST_IDLE;
                  end else begin
                     gap_cnt <= gap_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dac_frame_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dac_frame_serializer                                       |
// | Brief    : Self-checking bench for dac_frame_serializer (DIV=2, GAP=2).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_dac_frame_serializer;

   localparam int N_DAC   = 12;
   localparam int DIV     = 2;
   localparam int GAP     = 2;
   localparam int SH_CYC  = 16 * 2 * DIV;   // Sync-low clocks per frame
   localparam int GAP_CYC = GAP * 2 * DIV;  // Sync-high gap clocks after a frame

   logic             clock_In     = 1'b0;
   logic             Reset        = 1'b1;
   logic             start        = 1'b0;
   logic             sample_valid = 1'b0;
   logic [N_DAC-1:0] data_In      = '0;
   logic             Sclk_DAC;
   logic             Sync;
   logic             Data_DAC;
   logic             busy;
   logic             frame_done;
   logic             overrun;

   dac_frame_serializer #(
      .N_DAC        (N_DAC),
      .DIV          (DIV),
      .GAP          (GAP)
   ) dut (
      .clock_In     (clock_In),
      .Reset        (Reset),
      .start        (start),
      .sample_valid (sample_valid),
      .data_In      (data_In),
      .Sclk_DAC     (Sclk_DAC),
      .Sync         (Sync),
      .Data_DAC     (Data_DAC),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun      (overrun)
   );

   always #5 clock_In = ~clock_In;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   // Reference: frame = 0000 followed by (sample + 2048) as a 12-bit unsigned code
   function automatic logic [15:0] ref_frame(input logic [11:0] d);
      int v;
      v = int'($signed(d)) + 2048;
      return 16'(v);
   endfunction

   // ---------------- reference model (cycle-level timing from frame rules) ----------------
   int          cyc       = 0;
   int          last_load = -1000000;
   int          earliest  = 0;
   bit          model_on  = 1'b0;
   bit          m_pend    = 1'b0;
   logic [11:0] m_pdata   = '0;
   logic [15:0] cur_frame = '0;
   logic [15:0] exp_q[$];
   int          frames_expected = 0;

   always @(negedge clock_In) begin
      int         k;
      bit         in_shift;
      logic [5:0] expv;
      logic [5:0] got;
      if (model_on) begin
         cyc++;
         k        = cyc - last_load;
         in_shift = (k >= 1) && (k <= SH_CYC);
         if (k == 0) begin
            cur_frame = ref_frame(m_pdata);
            exp_q.push_back(cur_frame);
            frames_expected++;
         end
         expv[5] = !in_shift;
         expv[4] = (k >= 0) && (k <= SH_CYC + GAP_CYC);
         expv[3] = (k == SH_CYC + 1);
         expv[2] = in_shift ? (((k - 1) / DIV) % 2 == 0) : 1'b1;
         expv[1] = in_shift ? cur_frame[15 - (k - 1) / (2 * DIV)] : 1'b0;
         expv[0] = !Reset && sample_valid && m_pend && (k != 0);
         got     = {Sync, busy, frame_done, Sclk_DAC, Data_DAC, overrun};
         n_checks++;
         if (got !== expv) begin
            n_fail++;
            $display("FAIL outputs cyc=%0d {sync,busy,done,sclk,data,ovr} got %b expected %b",
                     cyc, got, expv);
         end
         if (Reset) begin
            m_pend          = 1'b0;
            last_load       = -1000000;
            earliest        = 0;
            frames_expected = frames_expected - exp_q.size();
            exp_q.delete();
         end else begin
            if (k == 0) earliest = cyc + SH_CYC + GAP_CYC;
            if ((k != 0) && (cyc >= earliest) && start && m_pend) last_load = cyc + 1;
            if (sample_valid) begin
               m_pend  = 1'b1;
               m_pdata = data_In;
            end else if (k == 0) begin
               m_pend = 1'b0;
            end
         end
      end else if (Reset) begin
         model_on = 1'b1;
      end
   end

   // ---------------- monitor: deserialize on SCLK falling edges, score at Sync rise ----------------
   bit          mon_on      = 1'b0;
   bit          prev_sync   = 1'b1;
   bit          prev_sclk   = 1'b1;
   bit          aborted     = 1'b0;
   int          nbits       = 0;
   int          frames_seen = 0;
   int          done_cnt    = 0;
   int          ovr_cnt     = 0;
   int          low_len     = 0;
   int          last_low    = 0;
   logic [15:0] shreg       = '0;
   logic [15:0] last_frame  = '0;

   always @(negedge clock_In) begin
      logic [15:0] e;
      if (mon_on) begin
         if (frame_done === 1'b1) done_cnt++;
         if (overrun === 1'b1) ovr_cnt++;
         if (Reset) aborted = 1'b1;
         if (prev_sync && !Sync) begin
            nbits   = 0;
            shreg   = '0;
            aborted = 1'b0;
            low_len = 0;
         end
         if (!Sync) low_len++;
         if (!Sync && prev_sclk && !Sclk_DAC) begin
            shreg = {shreg[14:0], Data_DAC};
            nbits++;
         end
         if (!prev_sync && Sync) begin
            if (aborted) begin
               aborted = 1'b0;
            end else begin
               frames_seen++;
               last_frame = shreg;
               last_low   = low_len;
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL frame_unexpected: got %h expected none", shreg);
               end else begin
                  e = exp_q.pop_front();
                  if ((nbits != 16) || (shreg !== e)) begin
                     n_fail++;
                     $display("FAIL frame_data: got %h (%0d bits) expected %h (16 bits)",
                              shreg, nbits, e);
                  end
               end
            end
         end
      end else if (Reset) begin
         mon_on = 1'b1;
      end
      prev_sync = Sync;
      prev_sclk = Sclk_DAC;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clock_In);
      #1;
   endtask

   task automatic send(input logic [11:0] d);
      sample_valid = 1'b1;
      data_In      = d;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((busy || m_pend) && (n < budget)) begin
         tick();
         n++;
      end
      n_checks++;
      if (busy || m_pend) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%b pending=%b after %0d cycles, expected idle", busy, m_pend, budget);
      end
      tick();
   endtask

   task automatic wait_sync_low(input int budget);
      int n;
      n = 0;
      while ((Sync !== 1'b0) && (n < budget)) begin
         tick();
         n++;
      end
      n_checks++;
      if (Sync !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_sync_low: Sync=%b after %0d cycles, expected 0", Sync, budget);
      end
   endtask

   logic [11:0] dir_d [3] = '{12'h000, 12'h800, 12'h7FF};
   logic [15:0] dir_f [3] = '{16'h0800, 16'h0000, 16'h0FFF};

   initial begin
      int fr0;
      int done0;
      int ovr0;
      bit sync_moved;

      Reset = 1'b1;
      start = 1'b0;
      repeat (3) tick();
      check("reset_sync",  32'(Sync),       32'd1);
      check("reset_sclk",  32'(Sclk_DAC),   32'd1);
      check("reset_data",  32'(Data_DAC),   32'd0);
      check("reset_busy",  32'(busy),       32'd0);
      check("reset_done",  32'(frame_done), 32'd0);
      check("reset_ovr",   32'(overrun),    32'd0);
      Reset = 1'b0;
      start = 1'b1;
      tick();

      // Code mapping at zero and both full-scale ends
      for (int i = 0; i < 3; i++) begin
         fr0   = frames_seen;
         done0 = done_cnt;
         send(dir_d[i]);
         wait_idle(300);
         check("dir_frame_count", 32'(frames_seen - fr0), 32'd1);
         check("dir_frame_value", 32'(last_frame),        32'(dir_f[i]));
         check("dir_done_pulses", 32'(done_cnt - done0),  32'd1);
         check("dir_sync_low_len", 32'(last_low),         32'(SH_CYC));
      end

      // Two strobes while a frame is on the wire: one overrun, latest sample sent next
      ovr0 = ovr_cnt;
      send(12'h0AA);
      wait_sync_low(50);
      send(12'h123);
      repeat (5) tick();
      send(12'h456);
      wait_idle(400);
      check("overrun_pulses",      32'(ovr_cnt - ovr0), 32'd1);
      check("after_overrun_frame", 32'(last_frame),     32'h0C56);

      // Reset in the middle of bit 7 drops the frame
      fr0   = frames_seen;
      done0 = done_cnt;
      send(12'h3C5);
      wait_sync_low(50);
      repeat (26) tick();
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      check("midreset_sync", 32'(Sync),     32'd1);
      check("midreset_busy", 32'(busy),     32'd0);
      check("midreset_sclk", 32'(Sclk_DAC), 32'd1);
      repeat (100) tick();
      check("midreset_no_done",  32'(done_cnt - done0),  32'd0);
      check("midreset_no_frame", 32'(frames_seen - fr0), 32'd0);

      // start low holds a pending sample back; raising it launches the frame
      start = 1'b0;
      send(12'h5A5);
      sync_moved = 1'b0;
      repeat (40) begin
         tick();
         if (Sync !== 1'b1 || busy !== 1'b0) sync_moved = 1'b1;
      end
      check("start_low_blocks", 32'(sync_moved), 32'd0);
      start = 1'b1;
      tick();
      check("start_rise_load", 32'(busy), 32'd1);
      wait_idle(300);
      check("start_rise_frame", 32'(last_frame), 32'h0DA5);

      // Samples every 80 clocks keep up without overrun
      ovr0 = ovr_cnt;
      fr0  = frames_seen;
      repeat (5) begin
         send(12'($urandom));
         repeat (79) tick();
      end
      wait_idle(300);
      check("stream_no_overrun", 32'(ovr_cnt - ovr0),    32'd0);
      check("stream_frames",     32'(frames_seen - fr0), 32'd5);

      // Random strobes, data and start toggling
      repeat (2500) begin
         sample_valid = ($urandom_range(0, 99) < 4);
         data_In      = 12'($urandom);
         if ($urandom_range(0, 149) == 0) start = ~start;
         tick();
      end
      sample_valid = 1'b0;
      start        = 1'b1;
      wait_idle(500);
      repeat (5) tick();

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("frames_total",     32'(frames_seen),  32'(frames_expected));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
